// File: rtl/slot_map_ctrl.sv
// slot_map_ctrl: MSX primary/secondary slot registers with CPU decode and a sequenced host access port
module slot_map_ctrl #(
    parameter logic [7:0] PSLOT_INIT = 8'h00,
    parameter logic [7:0] SSLOT_INIT = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic        cpu_mreq,
    input  logic        cpu_iorq,
    input  logic [3:0]  expander_en,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [2:0]  host_sel,
    input  logic [7:0]  host_wdata,
    output logic        host_busy,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic [7:0]  primary_reg,
    output logic [1:0]  active_slot,
    output logic [1:0]  active_subslot,
    output logic [7:0]  data,
    output logic        output_rq
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t     state_q;
    logic [7:0] primary_q;
    logic [7:0] sub_q [4];
    logic       we_q;
    logic [2:0] sel_q;
    logic [7:0] wdata_q;
    logic       ack_q;
    logic [7:0] rdata_q;
    logic [1:0] page;
    logic [1:0] slot3;
    logic       pwr, prd, ss_hit, swr, srd;
    logic [7:0] host_val;

    // CPU decode, slot resolution, CPU read mux and host target value; the 0xFFFF register belongs to the page-3 slot
    always_comb begin
        page           = cpu_addr[15:14];
        slot3          = primary_q[7:6];
        pwr            = cpu_req & cpu_iorq & cpu_wr & (cpu_addr[7:0] == 8'hA8);
        prd            = cpu_iorq & cpu_rd & (cpu_addr[7:0] == 8'hA8);
        ss_hit         = cpu_mreq & (cpu_addr == 16'hFFFF) & expander_en[slot3];
        swr            = ss_hit & cpu_wr & cpu_req;
        srd            = ss_hit & cpu_rd;
        active_slot    = primary_q[{page, 1'b0} +: 2];
        active_subslot = sub_q[active_slot][{page, 1'b0} +: 2];
        data           = srd ? ~sub_q[slot3] : prd ? primary_q : 8'hFF;
        output_rq      = srd | prd;
        host_val       = sel_q[2] ? ((sel_q[1:0] == 2'd0) ? primary_q : 8'hFF) : sub_q[sel_q[1:0]];
    end

    // Register file and host FSM; host commits only in cycles without cpu_req so the two writers never collide
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            primary_q <= PSLOT_INIT;
            for (int i = 0; i < 4; i++) sub_q[i] <= SSLOT_INIT;
            we_q      <= 1'b0;
            sel_q     <= 3'd0;
            wdata_q   <= 8'h00;
            ack_q     <= 1'b0;
            rdata_q   <= 8'h00;
        end else begin
            ack_q <= 1'b0;
            if (pwr) primary_q <= cpu_data;
            if (swr) sub_q[slot3] <= cpu_data;
            case (state_q)
                IDLE: if (host_req) begin
                    we_q    <= host_we;
                    sel_q   <= host_sel;
                    wdata_q <= host_wdata;
                    state_q <= WAIT;
                end
                WAIT: if (!cpu_req) begin
                    if (we_q && !sel_q[2]) sub_q[sel_q[1:0]] <= wdata_q;
                    if (we_q && sel_q == 3'd4) primary_q <= wdata_q;
                    if (!we_q || sel_q > 3'd4) rdata_q <= host_val;
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign host_busy   = (state_q != IDLE);
    assign host_ack    = ack_q;
    assign host_rdata  = rdata_q;
    assign primary_reg = primary_q;
endmodule

// File: tb/tb_slot_map_ctrl.sv
// tb_slot_map_ctrl: directed scenario bench for slot_map_ctrl
module tb_slot_map_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_req, cpu_wr, cpu_rd, cpu_mreq, cpu_iorq;
    logic [3:0]  expander_en;
    logic        host_req, host_we;
    logic [2:0]  host_sel;
    logic [7:0]  host_wdata;
    logic        host_busy, host_ack;
    logic [7:0]  host_rdata, primary_reg, data;
    logic [1:0]  active_slot, active_subslot;
    logic        output_rq;
    int          checks = 0;
    int          failures = 0;

    slot_map_ctrl dut (
        .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_mreq(cpu_mreq),
        .cpu_iorq(cpu_iorq), .expander_en(expander_en), .host_req(host_req),
        .host_we(host_we), .host_sel(host_sel), .host_wdata(host_wdata),
        .host_busy(host_busy), .host_ack(host_ack), .host_rdata(host_rdata),
        .primary_reg(primary_reg), .active_slot(active_slot),
        .active_subslot(active_subslot), .data(data), .output_rq(output_rq)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        cpu_req = 0; cpu_wr = 0; cpu_rd = 0; cpu_mreq = 0; cpu_iorq = 0;
        cpu_addr = 16'h0000; cpu_data = 8'h00;
    endtask

    task automatic io_write(input logic [7:0] d);
        cpu_addr = 16'h00A8; cpu_data = d; cpu_iorq = 1; cpu_wr = 1; cpu_req = 1;
        tick();
        bus_idle();
    endtask

    task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_data = d; cpu_mreq = 1; cpu_wr = 1; cpu_req = 1;
        tick();
        bus_idle();
    endtask

    task automatic set_read(input logic io, input logic [15:0] a);
        cpu_addr = a; cpu_iorq = io; cpu_mreq = !io; cpu_rd = 1;
        #1;
    endtask

    task automatic host_txn(input logic we, input logic [2:0] sel, input logic [7:0] wd,
                            output logic [7:0] rd, output int lat);
        host_req = 1; host_we = we; host_sel = sel; host_wdata = wd;
        lat = -1;
        tick();
        host_req = 0;
        for (int n = 1; n <= 20; n++) begin
            if (host_ack) begin
                lat = n;
                break;
            end
            tick();
        end
        rd = host_rdata;
        tick();
    endtask

    task automatic test_reset;
        bus_idle();
        expander_en = 4'b0000;
        host_req = 0; host_we = 0; host_sel = 0; host_wdata = 0;
        tick(); tick();
        reset_n = 1;
        tick();
        checks++; if (primary_reg !== 8'h00) begin failures++; $display("FAIL rst_primary got=%h exp=00", primary_reg); end
        checks++; if (active_slot !== 2'd0) begin failures++; $display("FAIL rst_slot got=%0d exp=0", active_slot); end
        checks++; if (active_subslot !== 2'd0) begin failures++; $display("FAIL rst_subslot got=%0d exp=0", active_subslot); end
        checks++; if (host_ack !== 1'b0 || host_busy !== 1'b0) begin failures++; $display("FAIL rst_host got=%b%b exp=00", host_ack, host_busy); end
        checks++; if (host_rdata !== 8'h00) begin failures++; $display("FAIL rst_rdata got=%h exp=00", host_rdata); end
        set_read(1, 16'h00A8);
        checks++; if (data !== 8'h00 || output_rq !== 1'b1) begin failures++; $display("FAIL rst_ioread got=%h/%b exp=00/1", data, output_rq); end
        bus_idle();
    endtask

    task automatic test_primary;
        logic [1:0] exp_slot [4];
        exp_slot[0] = 2'd0; exp_slot[1] = 2'd1; exp_slot[2] = 2'd2; exp_slot[3] = 2'd3;
        io_write(8'hE4);
        checks++; if (primary_reg !== 8'hE4) begin failures++; $display("FAIL pri_reg got=%h exp=E4", primary_reg); end
        for (int p = 0; p < 4; p++) begin
            cpu_addr = 16'(p) << 14;
            #1;
            checks++; if (active_slot !== exp_slot[p]) begin failures++; $display("FAIL pri_page%0d got=%0d exp=%0d", p, active_slot, exp_slot[p]); end
        end
        set_read(1, 16'h12A8);
        checks++; if (data !== 8'hE4 || output_rq !== 1'b1) begin failures++; $display("FAIL pri_ioread got=%h/%b exp=E4/1", data, output_rq); end
        bus_idle();
        cpu_addr = 16'h00A8; cpu_iorq = 1; cpu_wr = 1; cpu_data = 8'h11;
        tick();
        bus_idle();
        checks++; if (primary_reg !== 8'hE4) begin failures++; $display("FAIL pri_noreq got=%h exp=E4", primary_reg); end
    endtask

    task automatic test_subslot;
        expander_en = 4'b1000;
        io_write(8'hC0);
        mem_write(16'hFFFF, 8'h1B);
        set_read(0, 16'hFFFF);
        checks++; if (data !== 8'hE4 || output_rq !== 1'b1) begin failures++; $display("FAIL sub_read got=%h/%b exp=E4/1", data, output_rq); end
        bus_idle();
        cpu_addr = 16'hC000;
        #1;
        checks++; if (active_slot !== 2'd3 || active_subslot !== 2'd0) begin failures++; $display("FAIL sub_page3 got=%0d/%0d exp=3/0", active_slot, active_subslot); end
        cpu_addr = 16'h4000;
        #1;
        checks++; if (active_slot !== 2'd0 || active_subslot !== 2'd0) begin failures++; $display("FAIL sub_page1 got=%0d/%0d exp=0/0", active_slot, active_subslot); end
        io_write(8'h3F);
        cpu_addr = 16'h4000;
        #1;
        checks++; if (active_slot !== 2'd3 || active_subslot !== 2'd2) begin failures++; $display("FAIL sub_page1b got=%0d/%0d exp=3/2", active_slot, active_subslot); end
        io_write(8'h00);
        set_read(0, 16'hFFFF);
        checks++; if (data !== 8'hFF || output_rq !== 1'b0) begin failures++; $display("FAIL sub_noexp got=%h/%b exp=FF/0", data, output_rq); end
        bus_idle();
    endtask

    task automatic test_host_write;
        logic [7:0] rd;
        int lat;
        host_req = 1; host_we = 1; host_sel = 3'd2; host_wdata = 8'h55;
        #1;
        checks++; if (host_busy !== 1'b0) begin failures++; $display("FAIL hw_c0_busy got=%b exp=0", host_busy); end
        tick();
        host_req = 0;
        checks++; if (host_busy !== 1'b1 || host_ack !== 1'b0) begin failures++; $display("FAIL hw_c1 got=%b%b exp=10", host_busy, host_ack); end
        tick();
        checks++; if (host_ack !== 1'b1) begin failures++; $display("FAIL hw_c2_ack got=%b exp=1", host_ack); end
        tick();
        checks++; if (host_ack !== 1'b0 || host_busy !== 1'b0) begin failures++; $display("FAIL hw_c3 got=%b%b exp=00", host_ack, host_busy); end
        host_txn(0, 3'd2, 8'h00, rd, lat);
        checks++; if (rd !== 8'h55 || lat !== 2) begin failures++; $display("FAIL hw_readback got=%h/%0d exp=55/2", rd, lat); end
    endtask

    task automatic test_host_stall;
        logic [7:0] rd;
        int lat;
        expander_en = 4'b0100;
        io_write(8'h80);
        host_txn(1, 3'd2, 8'h00, rd, lat);
        checks++; if (lat !== 2) begin failures++; $display("FAIL st_pre got=%0d exp=2", lat); end
        host_req = 1; host_we = 1; host_sel = 3'd2; host_wdata = 8'h55;
        tick();
        host_req = 0;
        cpu_addr = 16'h1234; cpu_mreq = 1; cpu_rd = 1; cpu_req = 1;
        #1;
        checks++; if (host_busy !== 1'b1) begin failures++; $display("FAIL st_c1_busy got=%b exp=1", host_busy); end
        tick();
        cpu_addr = 16'hFFFF; cpu_mreq = 1; cpu_rd = 0; cpu_wr = 1; cpu_data = 8'hAA; cpu_req = 1;
        tick();
        cpu_wr = 0; cpu_rd = 1; cpu_req = 1;
        #1;
        checks++; if (data !== 8'h55 || host_ack !== 1'b0) begin failures++; $display("FAIL st_c3 got=%h/%b exp=55/0", data, host_ack); end
        tick();
        bus_idle();
        checks++; if (host_ack !== 1'b0 || host_busy !== 1'b1) begin failures++; $display("FAIL st_c4 got=%b%b exp=01", host_ack, host_busy); end
        tick();
        checks++; if (host_ack !== 1'b1) begin failures++; $display("FAIL st_c5_ack got=%b exp=1", host_ack); end
        tick();
        set_read(0, 16'hFFFF);
        checks++; if (data !== 8'hAA) begin failures++; $display("FAIL st_final got=%h exp=AA", data); end
        bus_idle();
        host_txn(0, 3'd2, 8'h00, rd, lat);
        checks++; if (rd !== 8'h55) begin failures++; $display("FAIL st_hostread got=%h exp=55", rd); end
    endtask

    task automatic test_back_to_back;
        host_req = 1; host_we = 1; host_sel = 3'd1; host_wdata = 8'h12;
        tick();
        host_req = 0;
        tick();
        host_req = 1; host_we = 1; host_sel = 3'd0; host_wdata = 8'hAB;
        #1;
        checks++; if (host_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack got=%b exp=1", host_ack); end
        tick();
        host_req = 1; host_we = 0; host_sel = 3'd1;
        #1;
        checks++; if (host_busy !== 1'b0) begin failures++; $display("FAIL b2b_ignored got=%b exp=0", host_busy); end
        tick();
        host_req = 0;
        checks++; if (host_busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", host_busy); end
        tick();
        checks++; if (host_ack !== 1'b1 || host_rdata !== 8'h12) begin failures++; $display("FAIL b2b_read got=%b/%h exp=1/12", host_ack, host_rdata); end
        tick();
    endtask

    task automatic test_reset_wait;
        logic [7:0] rd;
        int lat;
        int acks = 0;
        io_write(8'h39);
        host_req = 1; host_we = 1; host_sel = 3'd4; host_wdata = 8'h77;
        tick();
        host_req = 0; cpu_req = 1; cpu_addr = 16'h2000; cpu_mreq = 1; cpu_rd = 1;
        tick();
        checks++; if (host_busy !== 1'b1) begin failures++; $display("FAIL rw_busy got=%b exp=1", host_busy); end
        reset_n = 0;
        #1;
        checks++; if (host_busy !== 1'b0 || primary_reg !== 8'h00) begin failures++; $display("FAIL rw_async got=%b/%h exp=0/00", host_busy, primary_reg); end
        bus_idle();
        tick();
        reset_n = 1;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (host_ack) acks++;
        end
        checks++; if (acks !== 0 || primary_reg !== 8'h00 || host_busy !== 1'b0) begin failures++; $display("FAIL rw_noack got=%0d/%h/%b exp=0/00/0", acks, primary_reg, host_busy); end
        host_txn(0, 3'd2, 8'h00, rd, lat);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rw_subinit got=%h exp=00", rd); end
    endtask

    task automatic test_reserved;
        logic [7:0] rd;
        int lat;
        io_write(8'h39);
        host_txn(0, 3'd6, 8'h00, rd, lat);
        checks++; if (rd !== 8'hFF || lat !== 2) begin failures++; $display("FAIL rs_read got=%h/%0d exp=FF/2", rd, lat); end
        host_txn(1, 3'd7, 8'h12, rd, lat);
        checks++; if (lat !== 2 || primary_reg !== 8'h39) begin failures++; $display("FAIL rs_write got=%0d/%h exp=2/39", lat, primary_reg); end
        host_txn(0, 3'd0, 8'h00, rd, lat);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rs_sub0 got=%h exp=00", rd); end
        host_txn(0, 3'd4, 8'h00, rd, lat);
        checks++; if (rd !== 8'h39) begin failures++; $display("FAIL rs_pri got=%h exp=39", rd); end
        host_txn(1, 3'd4, 8'hC6, rd, lat);
        checks++; if (primary_reg !== 8'hC6) begin failures++; $display("FAIL rs_priwr got=%h exp=C6", primary_reg); end
    endtask

    initial begin
        test_reset();
        test_primary();
        test_subslot();
        test_host_write();
        test_host_stall();
        test_back_to_back();
        test_reset_wait();
        test_reserved();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/slot_map_ctrl.md
# slot_map_ctrl

Slot-map controller for the MSX slot subsystem. It owns the primary slot register (I/O port 0xA8) and the four secondary subslot registers (memory 0xFFFF of each expanded primary slot). It resolves the active primary slot and subslot for every CPU address, and serves the OSD/loader host through a request/acknowledge port. Host accesses are sequenced so they never land in a cycle carrying a CPU bus strobe.

## Interface
- PSLOT_INIT, 8'h00, reset value of the primary slot register
- SSLOT_INIT, 8'h00, reset value of all four subslot registers
- clk  in  1  system clock; all state changes on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- cpu_addr  in  16  CPU address
- cpu_data  in  8  CPU write data
- cpu_req  in  1  single-cycle bus strobe; qualifies cpu_wr
- cpu_wr, cpu_rd  in  1 each  write/read cycle flags
- cpu_mreq, cpu_iorq  in  1 each  memory/IO cycle flags
- expander_en  in  4  bit n = primary slot n is expanded (includes forced expansion)
- host_req  in  1  host access request, sampled only in IDLE
- host_we  in  1  1 = write, 0 = read
- host_sel  in  3  0..3 = subslot register of slot n; 4 = primary register; 5..7 = reserved
- host_wdata  in  8  host write data
- host_busy  out  1  state != IDLE
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  8  register value captured at commit; valid while host_ack=1
- primary_reg  out  8  primary slot register
- active_slot  out  2  primary_reg[2*cpu_addr[15:14] +: 2]
- active_subslot  out  2  subslot_reg[active_slot][2*cpu_addr[15:14] +: 2]
- data  out  8  CPU read data (8'hFF when output_rq=0)
- output_rq  out  1  block drives the CPU read bus

## Operation
- Decodes:
  - pwr = cpu_req & cpu_iorq & cpu_wr & cpu_addr[7:0]==8'hA8
  - prd = cpu_iorq & cpu_rd & cpu_addr[7:0]==8'hA8
  - ss_hit = cpu_mreq & cpu_addr==16'hFFFF & expander_en[primary_reg[7:6]]
  - swr = ss_hit & cpu_wr & cpu_req
  - srd = ss_hit & cpu_rd
- Register updates:
  - pwr: primary_reg <= cpu_data
  - swr: subslot_reg[primary_reg[7:6]] <= cpu_data. The page-3 slot is used, not active_slot, although the two are identical at 0xFFFF.
- Read path, combinational:
  - srd: data = ~subslot_reg[primary_reg[7:6]]
  - prd: data = primary_reg
  - otherwise: data = 8'hFF
  - output_rq = srd | prd
- Subslot registers of non-expanded slots remain host-accessible. active_subslot always reflects the stored value. Consumers ignore it when the slot is not expanded.
- Host FSM:
  - IDLE: when host_req=1, latch host_we/host_sel/host_wdata and go to WAIT.
  - WAIT: when cpu_req=0 this cycle, commit at the edge and go to ACK. Otherwise stay. There is no timeout.
    - Write commit: target register <= latched wdata.
    - Read commit: host_rdata <= target value, non-inverted.
  - ACK: host_ack=1 for exactly one cycle, then IDLE. host_req seen in ACK is ignored.
- Reserved host_sel (5..7): the commit performs no write, host_rdata <= 8'hFF, and the ack is still issued.
- CPU and host writes never share an edge. A CPU write to the same register during WAIT is overwritten by the later host commit (last writer wins).

## Timing
- Reset (reset_n=0, asynchronous) drives:
  - primary_reg=PSLOT_INIT and all subslot_reg=SSLOT_INIT
  - state=IDLE, host_ack=0, host_busy=0, host_rdata=8'h00
- Reset mid-transaction discards the pending host access; no ack is issued.
- CPU register writes take effect at the edge ending the cpu_req cycle. active_slot/active_subslot/data reflect the new value in the next cycle.
- data/output_rq/active_* are combinational from the registers and the current address: zero latency.
- Host latency from the host_req cycle (cycle 0):
  - minimum: commit at end of cycle 1, host_ack in cycle 2
  - each cycle with cpu_req=1 in WAIT adds one cycle
- The earliest back-to-back host_req is sampled in the cycle after host_ack.

## Test plan
- Reset: release reset_n with defaults -> primary_reg=00, active_slot=0, active_subslot=0, host_ack=0, a read of IO 0xA8 returns 00 with output_rq=1.
- Primary write/read: IO write 0xA8=8'hE4 -> addr 0x0000 active_slot=0, 0x4000 ->1, 0x8000 ->2, 0xC000 ->3; IO read 0xA8 returns E4.
- Subslot write: expander_en=4'b1000, primary_reg=C0:
  - mem write FFFF=8'h1B -> mem read FFFF returns E4 with output_rq=1, active_subslot at 0xC000 = 0
  - after primary_reg=00, a read of FFFF returns FF with output_rq=0 (slot 0 not expanded)
- Host write, idle bus: host_req/we/sel=2/wdata=8'h55 in cycle 0 with cpu_req=0 -> host_busy from cycle 1, host_ack in cycle 2, subslot_reg[2]=55 visible via host read (rdata=55).
- Host stalled: cpu_req=1 in cycles 1-3 with the host request in WAIT -> no commit until cycle 4, host_ack in cycle 5; a CPU write of 8'hAA to FFFF (slot 2 selected) in cycle 2 is overwritten, so the final value is 55.
- Reset in WAIT / reserved select: reset_n low during WAIT -> no ack, state IDLE, registers at init; host read with sel=6 -> ack with host_rdata=FF, no register changes.
